// File: rtl/wb_cpu_arbiter_pkg.sv
// Shared definitions for the CPU-side Wishbone arbiter: FSM encodings,
// owner identifiers and the Wishbone cycle/burst type constants.
package wb_cpu_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_OWN_I  = 2'd1,
        ARB_OWN_D  = 2'd2,
        ARB_TO_GAP = 2'd3
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_CONST   = 3'b001;
    localparam logic [2:0] WB_CTI_INC     = 3'b010;
    localparam logic [2:0] WB_CTI_EOB     = 3'b111;

    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
    localparam logic [1:0] WB_BTE_WRAP4   = 2'b01;
    localparam logic [1:0] WB_BTE_WRAP8   = 2'b10;
    localparam logic [1:0] WB_BTE_WRAP16  = 2'b11;

    function automatic arb_state_e owner_state(input logic owner);
        return owner ? ARB_OWN_D : ARB_OWN_I;
    endfunction

endpackage

// File: rtl/wb_cpu_arbiter_if.sv
// One Wishbone master port; 'master' drives the request, 'slave' answers it.
interface wb_cpu_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:2] addr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (
        output cyc, stb, we, addr, cti, bte, sel, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, addr, cti, bte, sel, dat_w,
        output dat_r, ack
    );
endinterface

// File: rtl/wb_cpu_arbiter.sv
// Merges the ICMU and DCMU Wishbone masters onto one bus with round-robin,
// cyc-held grants and a per-transfer timeout that synthesises an ack.
module wb_cpu_arbiter
    import wb_cpu_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TO_BITS = 11,
    parameter logic [31:0] TO_DATA = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_cpu_arbiter_if.slave  ibus,
    wb_cpu_arbiter_if.slave  dbus,
    wb_cpu_arbiter_if.master mbus,
    input  logic             to_clr,
    output logic             to_flag,
    output logic             to_src
);

    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic               r_last;
    logic               r_to_flag;
    logic               r_to_src;
    logic [TO_BITS-1:0] r_cnt;

    logic w_i_req;
    logic w_d_req;
    logic w_owning;
    logic w_own_cyc;
    logic w_own_stb;
    logic w_oth_req;
    logic w_timeout;

    // r_last names the current owner while owning and in TO_GAP.
    always_comb begin
        w_i_req   = ibus.cyc & ibus.stb;
        w_d_req   = dbus.cyc & dbus.stb;
        w_owning  = (r_state == ARB_OWN_I) || (r_state == ARB_OWN_D);
        w_own_cyc = r_last ? dbus.cyc : ibus.cyc;
        w_own_stb = r_last ? dbus.stb : ibus.stb;
        w_oth_req = r_last ? w_i_req  : w_d_req;
        w_timeout = (TIMEOUT != 0) && w_owning && w_own_stb && !mbus.ack
                    && (r_cnt == TO_LAST);
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_i_req && w_d_req)
                    w_state_nxt = owner_state(~r_last);
                else if (w_d_req)
                    w_state_nxt = ARB_OWN_D;
                else if (w_i_req)
                    w_state_nxt = ARB_OWN_I;
            end
            ARB_OWN_I, ARB_OWN_D: begin
                if (w_timeout)
                    w_state_nxt = ARB_TO_GAP;
                else if (!w_own_cyc)
                    w_state_nxt = w_oth_req ? owner_state(~r_last) : ARB_IDLE;
            end
            ARB_TO_GAP: begin
                if (w_own_cyc)
                    w_state_nxt = owner_state(r_last);
                else
                    w_state_nxt = w_oth_req ? owner_state(~r_last) : ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ARB_IDLE;
            r_last    <= OWNER_I;
            r_cnt     <= '0;
            r_to_flag <= 1'b0;
            r_to_src  <= OWNER_I;
        end else begin
            // NOTE: registers use non-blocking assignments so every update in
            // this block sees the pre-edge values, independent of statement order.
            r_state <= w_state_nxt;

            if (w_state_nxt == ARB_OWN_I)
                r_last <= OWNER_I;
            else if (w_state_nxt == ARB_OWN_D)
                r_last <= OWNER_D;

            if ((w_state_nxt != r_state) || mbus.ack || !w_owning || !w_own_stb)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + TO_BITS'(1);

            // A timeout in the same cycle as to_clr wins.
            if (w_timeout) begin
                r_to_flag <= 1'b1;
                r_to_src  <= r_last;
            end else if (to_clr) begin
                r_to_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned and no latch is inferred.
        mbus.cyc   = 1'b0;
        mbus.stb   = 1'b0;
        mbus.we    = 1'b0;
        mbus.addr  = '0;
        mbus.cti   = '0;
        mbus.bte   = '0;
        mbus.sel   = '0;
        mbus.dat_w = '0;
        ibus.ack   = 1'b0;
        dbus.ack   = 1'b0;
        ibus.dat_r = w_timeout ? TO_DATA : mbus.dat_r;
        dbus.dat_r = w_timeout ? TO_DATA : mbus.dat_r;

        unique case (r_state)
            ARB_OWN_I: begin
                mbus.cyc   = ibus.cyc;
                mbus.stb   = ibus.stb & ~w_timeout;
                mbus.we    = ibus.we;
                mbus.addr  = ibus.addr;
                mbus.cti   = ibus.cti;
                mbus.bte   = ibus.bte;
                mbus.sel   = ibus.sel;
                mbus.dat_w = ibus.dat_w;
                ibus.ack   = mbus.ack | w_timeout;
            end
            ARB_OWN_D: begin
                mbus.cyc   = dbus.cyc;
                mbus.stb   = dbus.stb & ~w_timeout;
                mbus.we    = dbus.we;
                mbus.addr  = dbus.addr;
                mbus.cti   = dbus.cti;
                mbus.bte   = dbus.bte;
                mbus.sel   = dbus.sel;
                mbus.dat_w = dbus.dat_w;
                dbus.ack   = mbus.ack | w_timeout;
            end
            default: ;
        endcase
    end

    assign to_flag = r_to_flag;
    assign to_src  = r_to_src;

endmodule

// File: tb/tb_wb_cpu_arbiter.sv
// Directed bench for wb_cpu_arbiter: acks are scored against a queue of
// expected (owner, data) pairs; bus ownership and status are checked inline.
module tb_wb_cpu_arbiter;
    import wb_cpu_arbiter_pkg::*;

    localparam int unsigned TMO = 8;

    typedef struct {
        logic        src;
        logic [31:0] data;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic to_clr = 1'b0;
    logic to_flag;
    logic to_src;

    wb_cpu_arbiter_if ibus ();
    wb_cpu_arbiter_if dbus ();
    wb_cpu_arbiter_if mbus ();

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    wb_cpu_arbiter #(
        .TIMEOUT (TMO),
        .TO_BITS (4),
        .TO_DATA (32'hFFFF_FFFF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ibus    (ibus),
        .dbus    (dbus),
        .mbus    (mbus),
        .to_clr  (to_clr),
        .to_flag (to_flag),
        .to_src  (to_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic expect_ack(input logic src, input logic [31:0] data);
        exp_t e;
        e.src  = src;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic idle_all();
        ibus.cyc = 1'b0; ibus.stb = 1'b0; ibus.we = 1'b0; ibus.addr = '0;
        ibus.cti = '0; ibus.bte = '0; ibus.sel = '0; ibus.dat_w = '0;
        dbus.cyc = 1'b0; dbus.stb = 1'b0; dbus.we = 1'b0; dbus.addr = '0;
        dbus.cti = '0; dbus.bte = '0; dbus.sel = '0; dbus.dat_w = '0;
        mbus.ack = 1'b0; mbus.dat_r = '0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        to_clr = 1'b0;
        idle_all();
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Ack scoreboard: every observed ack must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ibus.ack || dbus.ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {30'd0, ibus.ack, dbus.ack}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("ack_owner", {30'd0, ibus.ack, dbus.ack},
                      e.src ? 32'd1 : 32'd2);
                check(e.src ? "d_ack_data" : "i_ack_data",
                      e.src ? dbus.dat_r : ibus.dat_r, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_all();
        rst_n = 1'b0;
        #12;
        check1("rst_m_cyc", mbus.cyc, 1'b0);
        check1("rst_m_stb", mbus.stb, 1'b0);
        check("rst_m_addr", 32'(mbus.addr), 32'd0);
        check1("rst_i_ack", ibus.ack, 1'b0);
        check1("rst_d_ack", dbus.ack, 1'b0);
        check1("rst_to_flag", to_flag, 1'b0);
        check1("rst_to_src", to_src, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single I read, slave acks on the second owned cycle
        ibus.cyc = 1'b1; ibus.stb = 1'b1; ibus.addr = 30'h400; ibus.sel = 4'hF;
        settle();
        check1("t1_idle_latency", mbus.cyc, 1'b0);
        tick(); settle();
        check("t1_addr", 32'(mbus.addr), 32'h400);
        check1("t1_cyc", mbus.cyc, 1'b1);
        tick();
        mbus.ack = 1'b1; mbus.dat_r = 32'hCAFE_0001;
        expect_ack(OWNER_I, 32'hCAFE_0001);
        settle();
        tick();
        mbus.ack = 1'b0; ibus.cyc = 1'b0; ibus.stb = 1'b0;
        settle();
        check1("t1_release_cyc", mbus.cyc, 1'b0);
        tick();
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // Simultaneous requests after reset: D first, then I back-to-back
        do_reset();
        ibus.cyc = 1'b1; ibus.stb = 1'b1; ibus.addr = 30'h440; ibus.sel = 4'hF;
        dbus.cyc = 1'b1; dbus.stb = 1'b1; dbus.we = 1'b1; dbus.addr = 30'h880;
        dbus.sel = 4'h3; dbus.dat_w = 32'h1234_5678;
        tick();
        mbus.ack = 1'b1; mbus.dat_r = 32'hD00D_0001;
        expect_ack(OWNER_D, 32'hD00D_0001);
        settle();
        check("t2_d_first_addr", 32'(mbus.addr), 32'h880);
        check1("t2_d_we", mbus.we, 1'b1);
        check("t2_d_sel", 32'(mbus.sel), 32'h3);
        check("t2_d_wdata", mbus.dat_w, 32'h1234_5678);
        tick();
        mbus.ack = 1'b0; dbus.cyc = 1'b0; dbus.stb = 1'b0; dbus.we = 1'b0;
        settle();
        tick();
        mbus.ack = 1'b1; mbus.dat_r = 32'hA5A5_0003;
        expect_ack(OWNER_I, 32'hA5A5_0003);
        settle();
        check("t2_i_next_addr", 32'(mbus.addr), 32'h440);
        check1("t2_i_cyc", mbus.cyc, 1'b1);
        check1("t2_i_we", mbus.we, 1'b0);
        tick();
        mbus.ack = 1'b0; ibus.cyc = 1'b0; ibus.stb = 1'b0;
        tick();
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // D 4-beat incrementing burst while I waits
        dbus.cyc = 1'b1; dbus.stb = 1'b1; dbus.addr = 30'h900;
        dbus.cti = WB_CTI_INC; dbus.bte = WB_BTE_LINEAR;
        tick();
        ibus.cyc = 1'b1; ibus.stb = 1'b1; ibus.addr = 30'h480;
        for (int b = 0; b < 4; b++) begin
            dbus.addr = 30'h900 + 30'(b);
            dbus.cti  = (b == 3) ? WB_CTI_EOB : WB_CTI_INC;
            mbus.ack  = 1'b1;
            mbus.dat_r = 32'hD000_0000 + 32'(b);
            expect_ack(OWNER_D, 32'hD000_0000 + 32'(b));
            settle();
            check($sformatf("t3_cti_b%0d", b), 32'(mbus.cti), (b == 3) ? 32'h7 : 32'h2);
            check($sformatf("t3_addr_b%0d", b), 32'(mbus.addr), 32'h900 + 32'(b));
            tick();
        end
        mbus.ack = 1'b0; dbus.cyc = 1'b0; dbus.stb = 1'b0; dbus.cti = '0;
        settle();
        tick();
        mbus.ack = 1'b1; mbus.dat_r = 32'h1111_0004;
        expect_ack(OWNER_I, 32'h1111_0004);
        settle();
        check("t3_i_after_addr", 32'(mbus.addr), 32'h480);
        tick();
        mbus.ack = 1'b0; ibus.cyc = 1'b0; ibus.stb = 1'b0;
        tick();
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // Silent slave with I as owner
        ibus.cyc = 1'b1; ibus.stb = 1'b1; ibus.addr = 30'hC00;
        mbus.dat_r = 32'h0000_1234;
        expect_ack(OWNER_I, 32'hFFFF_FFFF);
        for (int c = 1; c <= int'(TMO); c++) begin
            tick(); settle();
            check1($sformatf("t4_ack_c%0d", c), ibus.ack, c == int'(TMO));
            check1($sformatf("t4_stb_c%0d", c), mbus.stb, c != int'(TMO));
        end
        check1("t4_cyc_at_to", mbus.cyc, 1'b1);
        check1("t4_flag_pre", to_flag, 1'b0);
        tick();
        ibus.stb = 1'b0;
        settle();
        check1("t4_gap_cyc", mbus.cyc, 1'b0);
        check1("t4_flag", to_flag, 1'b1);
        check1("t4_src", to_src, 1'b0);
        tick(); settle();
        check1("t4_regrant_cyc", mbus.cyc, 1'b1);
        check("t4_regrant_addr", 32'(mbus.addr), 32'hC00);
        tick();
        ibus.cyc = 1'b0; to_clr = 1'b1;
        settle();
        check1("t4_flag_held", to_flag, 1'b1);
        tick();
        to_clr = 1'b0;
        settle();
        check1("t4_flag_cleared", to_flag, 1'b0);

        // Silent slave with D as owner
        tick();
        dbus.cyc = 1'b1; dbus.stb = 1'b1; dbus.addr = 30'hC40;
        expect_ack(OWNER_D, 32'hFFFF_FFFF);
        repeat (TMO) tick();
        tick();
        dbus.cyc = 1'b0; dbus.stb = 1'b0;
        settle();
        check1("t4d_gap_cyc", mbus.cyc, 1'b0);
        check1("t4d_flag", to_flag, 1'b1);
        check1("t4d_src", to_src, 1'b1);
        tick(); settle();
        check1("t4d_idle_cyc", mbus.cyc, 1'b0);
        check("t4d_drained", 32'(exp_q.size()), 32'd0);

        // Reset during beat 2 of a D burst
        tick();
        dbus.cyc = 1'b1; dbus.stb = 1'b1; dbus.addr = 30'h900; dbus.cti = WB_CTI_INC;
        tick();
        for (int b = 0; b < 2; b++) begin
            dbus.addr = 30'h900 + 30'(b);
            mbus.ack = 1'b1; mbus.dat_r = 32'hBEEF_0000 + 32'(b);
            expect_ack(OWNER_D, 32'hBEEF_0000 + 32'(b));
            settle();
            tick();
        end
        dbus.addr = 30'h902; mbus.ack = 1'b1; mbus.dat_r = 32'hDEAD_0002;
        #1 rst_n = 1'b0;
        #1;
        check1("t5_rst_cyc", mbus.cyc, 1'b0);
        check1("t5_rst_stb", mbus.stb, 1'b0);
        check("t5_rst_addr", 32'(mbus.addr), 32'd0);
        check("t5_rst_cti", 32'(mbus.cti), 32'd0);
        check1("t5_rst_d_ack", dbus.ack, 1'b0);
        check1("t5_rst_i_ack", ibus.ack, 1'b0);
        check1("t5_rst_flag", to_flag, 1'b0);
        idle_all();
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        settle();
        check1("t5_idle_cyc", mbus.cyc, 1'b0);
        tick();
        ibus.cyc = 1'b1; ibus.stb = 1'b1; ibus.addr = 30'h500;
        tick();
        mbus.ack = 1'b1; mbus.dat_r = 32'h5555_0005;
        expect_ack(OWNER_I, 32'h5555_0005);
        settle();
        check("t5_regrant_addr", 32'(mbus.addr), 32'h500);
        tick();
        mbus.ack = 1'b0; ibus.cyc = 1'b0; ibus.stb = 1'b0;
        tick();
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // Round-robin with both masters continuously requesting
        do_reset();
        ibus.cyc = 1'b1; ibus.stb = 1'b1; ibus.addr = 30'h600;
        dbus.cyc = 1'b1; dbus.stb = 1'b1; dbus.addr = 30'hA00;
        tick();
        for (int k = 0; k < 4; k++) begin
            mbus.ack = 1'b1; mbus.dat_r = 32'h7700_0000 + 32'(k);
            expect_ack((k % 2 == 0) ? OWNER_D : OWNER_I, 32'h7700_0000 + 32'(k));
            settle();
            check($sformatf("t6_grant_%0d", k), 32'(mbus.addr),
                  (k % 2 == 0) ? 32'hA00 : 32'h600);
            tick();
            mbus.ack = 1'b0;
            if (k % 2 == 0) begin dbus.cyc = 1'b0; dbus.stb = 1'b0; end
            else            begin ibus.cyc = 1'b0; ibus.stb = 1'b0; end
            settle();
            tick();
            ibus.cyc = 1'b1; ibus.stb = 1'b1;
            dbus.cyc = 1'b1; dbus.stb = 1'b1;
        end
        idle_all();
        tick();
        tick();
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
